// File: rtl/cpu_test_monitor.sv
// cpu_test_monitor: end-of-test monitor placed after the RV64I core.
// Watches the retire stream for the halt PC, waits a fixed drain window so
// in-flight writebacks reach x3 (gp), then latches a sticky verdict.
//
// Ports:
//   clk          - rising-edge clock
//   rst          - synchronous active-low reset
//   retire_valid - one instruction retired this cycle
//   retire_pc    - PC of the retiring instruction (qualified by retire_valid)
//   gp_value     - current architectural value of x3
//   done         - sticky, verdict available
//   pass         - sticky, halted with gp == 0
//   timeout      - sticky, cycle budget exhausted before halt
//   err_code     - gp latched at verdict time (0 on timeout)
//   cycle_count  - cycles spent in RUN and DRAIN (saturating)
//   retire_count - retires counted in RUN (saturating)
module cpu_test_monitor #(
  parameter logic [63:0] HALT_PC      = 64'h0000_0000_0000_001C,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [31:0] MAX_CYCLES   = 32'd10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire_valid,
  input  logic [63:0] retire_pc,
  input  logic [63:0] gp_value,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [63:0] err_code,
  output logic [31:0] cycle_count,
  output logic [31:0] retire_count
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t      state, state_n;
  logic [3:0]  drain_cnt, drain_cnt_n;
  logic        done_n, pass_n, timeout_n;
  logic [63:0] err_code_n;
  logic [31:0] cycle_count_n, retire_count_n;
  logic [31:0] cycle_inc, retire_inc;
  logic        at_limit;
  logic        halt_hit;

  assign cycle_inc  = (cycle_count == '1) ? cycle_count : cycle_count + 32'd1;
  assign retire_inc = (retire_count == '1) ? retire_count : retire_count + 32'd1;
  // The edge that would move cycle_count onto MAX_CYCLES is the timeout edge.
  assign at_limit   = (cycle_count == MAX_CYCLES - 32'd1);
  assign halt_hit   = retire_valid && (retire_pc == HALT_PC);

  always_comb begin
    state_n        = state;
    drain_cnt_n    = drain_cnt;
    done_n         = done;
    pass_n         = pass;
    timeout_n      = timeout;
    err_code_n     = err_code;
    cycle_count_n  = cycle_count;
    retire_count_n = retire_count;

    unique case (state)
      S_RUN: begin
        cycle_count_n = cycle_inc;
        if (retire_valid) retire_count_n = retire_inc;
        // Halt takes precedence over a coincident timeout edge.
        if (halt_hit) begin
          state_n     = S_DRAIN;
          drain_cnt_n = 4'(DRAIN_CYCLES);
        end else if (at_limit) begin
          state_n    = S_TIMEOUT;
          done_n     = 1'b1;
          timeout_n  = 1'b1;
          pass_n     = 1'b0;
          err_code_n = '0;
        end
      end
      S_DRAIN: begin
        cycle_count_n = cycle_inc;
        drain_cnt_n   = drain_cnt - 4'd1;
        // Drain completion takes precedence over a coincident timeout edge.
        if (drain_cnt == 4'd1) begin
          state_n    = S_DONE;
          done_n     = 1'b1;
          pass_n     = (gp_value == '0);
          err_code_n = gp_value;
        end else if (at_limit) begin
          state_n    = S_TIMEOUT;
          done_n     = 1'b1;
          timeout_n  = 1'b1;
          pass_n     = 1'b0;
          err_code_n = '0;
        end
      end
      default: begin
        // DONE and TIMEOUT are terminal; everything holds until reset.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_RUN;
      drain_cnt    <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      err_code     <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
    end else begin
      state        <= state_n;
      drain_cnt    <= drain_cnt_n;
      done         <= done_n;
      pass         <= pass_n;
      timeout      <= timeout_n;
      err_code     <= err_code_n;
      cycle_count  <= cycle_count_n;
      retire_count <= retire_count_n;
    end
  end

endmodule

// File: tb/tb_cpu_test_monitor.sv
// Self-checking bench for cpu_test_monitor. Three instances with different
// cycle budgets (10000, 50, 20) share one stimulus stream; each is compared
// every cycle against an edge-numbered reference model.
module tb_cpu_test_monitor;

  localparam logic [63:0] HALT = 64'h1C;
  localparam int DRAIN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        retire_valid = 1'b0;
  logic [63:0] retire_pc = '0;
  logic [63:0] gp_value = '0;

  logic [2:0]  done_o, pass_o, tmo_o;
  logic [63:0] err_o [3];
  logic [31:0] cyc_o [3];
  logic [31:0] rc_o  [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_test_monitor #(.HALT_PC(HALT), .DRAIN_CYCLES(DRAIN), .MAX_CYCLES(32'd10000)) dut0 (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .gp_value(gp_value), .done(done_o[0]), .pass(pass_o[0]), .timeout(tmo_o[0]),
    .err_code(err_o[0]), .cycle_count(cyc_o[0]), .retire_count(rc_o[0]));

  cpu_test_monitor #(.HALT_PC(HALT), .DRAIN_CYCLES(DRAIN), .MAX_CYCLES(32'd50)) dut1 (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .gp_value(gp_value), .done(done_o[1]), .pass(pass_o[1]), .timeout(tmo_o[1]),
    .err_code(err_o[1]), .cycle_count(cyc_o[1]), .retire_count(rc_o[1]));

  cpu_test_monitor #(.HALT_PC(HALT), .DRAIN_CYCLES(DRAIN), .MAX_CYCLES(32'd20)) dut2 (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .gp_value(gp_value), .done(done_o[2]), .pass(pass_o[2]), .timeout(tmo_o[2]),
    .err_code(err_o[2]), .cycle_count(cyc_o[2]), .retire_count(rc_o[2]));

  // Reference model: edge number since reset, edge of the halt retire,
  // and the verdict. The drain ends DRAIN edges after the halt edge.
  longint      max_c [3] = '{10000, 50, 20};
  longint      m_cyc [3];
  longint      m_rc  [3];
  longint      m_halt[3];
  logic        m_done[3], m_pass[3], m_tmo[3];
  logic [63:0] m_err [3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [63:0] pc, input logic [63:0] gp);
    for (int i = 0; i < 3; i++) begin
      if (!r) begin
        m_cyc[i] = 0; m_rc[i] = 0; m_halt[i] = -1;
        m_done[i] = 0; m_pass[i] = 0; m_tmo[i] = 0; m_err[i] = '0;
      end else if (!m_done[i]) begin
        m_cyc[i]++;
        if (m_halt[i] < 0) begin
          if (v) m_rc[i]++;
          if (v && pc == HALT) m_halt[i] = m_cyc[i];
          else if (m_cyc[i] == max_c[i]) begin m_done[i] = 1; m_tmo[i] = 1; end
        end else if (m_cyc[i] == m_halt[i] + DRAIN) begin
          m_done[i] = 1; m_pass[i] = (gp == 0); m_err[i] = gp;
        end else if (m_cyc[i] == max_c[i]) begin
          m_done[i] = 1; m_tmo[i] = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("done%0d", i),    {63'd0, done_o[i]}, {63'd0, m_done[i]});
      check($sformatf("pass%0d", i),    {63'd0, pass_o[i]}, {63'd0, m_pass[i]});
      check($sformatf("timeout%0d", i), {63'd0, tmo_o[i]},  {63'd0, m_tmo[i]});
      check($sformatf("err%0d", i),     err_o[i], m_err[i]);
      check($sformatf("cycles%0d", i),  {32'd0, cyc_o[i]}, 64'(m_cyc[i]));
      check($sformatf("retires%0d", i), {32'd0, rc_o[i]},  64'(m_rc[i]));
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [63:0] pc, input logic [63:0] gp);
    rst = r; retire_valid = v; retire_pc = pc; gp_value = gp;
    @(posedge clk);
    model_edge(r, v, pc, gp);
    #1;
    check_all();
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 64'h0, 64'h0);
  endtask

  task automatic idle(input int n, input logic [63:0] gp);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 64'h0, gp);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) m_halt[i] = -1;

    // Pass run
    do_reset(2);
    check("reset_done", {63'd0, done_o[0]}, 64'd0);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 64'(k * 4), 64'h0);
      if (k == 10 - 1) check("pass_early_done", {63'd0, done_o[0]}, 64'd0);
    end
    idle(2, 64'h0);
    check("pass_run_done", {63'd0, done_o[0]}, 64'd1);
    check("pass_run_pass", {63'd0, pass_o[0]}, 64'd1);
    check("pass_run_rc", {32'd0, rc_o[0]}, 64'd8);
    idle(3, 64'h0);

    // Fail run with late writeback: gp changes two cycles after the halt edge
    do_reset(2);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 64'(k * 4), 64'h0);
    step(1'b1, 1'b0, 64'h0, 64'h0);
    idle(5, 64'h5);
    check("fail_run_pass", {63'd0, pass_o[0]}, 64'd0);
    check("fail_run_err", err_o[0], 64'h5);

    // Timeout on the 50-cycle budget with a halt-free stream
    do_reset(2);
    for (int k = 0; k < 70; k++) step(1'b1, 1'b1, 64'h100 + 64'(k * 4), 64'h7);
    check("tmo_flag", {63'd0, tmo_o[1]}, 64'd1);
    check("tmo_cycles", {32'd0, cyc_o[1]}, 64'd50);
    check("tmo_err", err_o[1], 64'd0);

    // Halt on edge 19 with a 20-cycle budget: timeout aborts the drain
    do_reset(1);
    idle(18, 64'h0);
    step(1'b1, 1'b1, HALT, 64'h0);
    idle(6, 64'h0);
    check("sim19_timeout", {63'd0, tmo_o[2]}, 64'd1);

    // Halt on edge 16: drain completion coincides with the timeout edge
    do_reset(1);
    idle(15, 64'h3);
    step(1'b1, 1'b1, HALT, 64'h3);
    idle(6, 64'h3);
    check("sim16_timeout", {63'd0, tmo_o[2]}, 64'd0);
    check("sim16_err", err_o[2], 64'h3);

    // Gating: invalid halt PC, then a second halt retire inside DRAIN
    do_reset(1);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, HALT, 64'h0);
    step(1'b1, 1'b1, HALT, 64'h0);
    step(1'b1, 1'b1, HALT, 64'h0);
    idle(4, 64'h0);
    check("gate_rc", {32'd0, rc_o[0]}, 64'd1);

    // Mid-DRAIN reset, then a fresh pass run
    do_reset(1);
    step(1'b1, 1'b1, HALT, 64'h9);
    step(1'b1, 1'b0, 64'h0, 64'h9);
    do_reset(1);
    check("midrst_cycles", {32'd0, cyc_o[0]}, 64'd0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 64'(k * 4), 64'h0);
    idle(3, 64'h0);
    check("midrst_pass", {63'd0, pass_o[0]}, 64'd1);

    // Randomized episodes
    for (int e = 0; e < 40; e++) begin
      int len;
      do_reset(1 + int'($urandom_range(1, 0)));
      len = int'($urandom_range(60, 5));
      for (int k = 0; k < len; k++) begin
        logic        v;
        logic [63:0] pc, gp;
        v  = 1'($urandom_range(1, 0));
        pc = ($urandom_range(3, 0) == 0) ? HALT : 64'($urandom_range(15, 0) * 4);
        gp = ($urandom_range(3, 0) == 0) ? 64'h0 : {32'($urandom), 32'($urandom)};
        step(($urandom_range(49, 0) == 0) ? 1'b0 : 1'b1, v, pc, gp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
